// File: rtl/parity_pkg.sv
// Shared types for the framed parity checker: FSM state encoding and
// parity-mode constants.
package parity_pkg;

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
// Synchronous active-high reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on request unless already at the maximum value
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/frame_parity_checker.sv
// Serial framed parity checker. Deserialises DATA_BITS data bits (LSB first)
// followed by one parity bit, checks parity against the mode latched at the
// start of the frame, and presents the word plus an error flag.
// Build option: define PARITY_ERRCNT_EN to build the saturating error
// counter; otherwise err_count is tied to zero.
module frame_parity_checker #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x,
    input  logic                 x_valid,
    input  logic                 odd_mode,
    output logic                 z,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic [DATA_BITS-1:0] data_out,
    output logic [CNT_W-1:0]     err_count
);

    import parity_pkg::*;

    localparam int            BC_W = $clog2(DATA_BITS);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   mode_q, mode_d;
    logic                   z_q, z_d;
    logic                   frame_done_q, frame_done_d;
    logic                   parity_err_q, parity_err_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;

    // Next-state logic: shift data bits in, then check the parity bit.
    // Idle cycles (x_valid=0) hold everything except the frame_done pulse.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        mode_d       = mode_q;
        z_d          = z_q;
        frame_done_d = 1'b0;
        parity_err_d = parity_err_q;
        data_out_d   = data_out_q;

        if (x_valid) begin
            case (state_q)
                S_DATA: begin
                    shreg_d[bit_cnt_q] = x;
                    z_d                = z_q ^ x;
                    // Mode is frozen for the whole frame at its first bit
                    if (bit_cnt_q == '0) begin
                        mode_d = odd_mode;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = S_PAR;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_PAR: begin
                    parity_err_d = (x != (z_q ^ mode_q));
                    data_out_d   = shreg_q;
                    frame_done_d = 1'b1;
                    z_d          = 1'b0;
                    state_d      = S_DATA;
                end
                default: begin
                    state_d = S_DATA;
                end
            endcase
        end
    end

    // State and output registers; reset wins over any valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_DATA;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            mode_q       <= PAR_EVEN;
            z_q          <= 1'b0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            mode_q       <= mode_d;
            z_q          <= z_d;
            frame_done_q <= frame_done_d;
            parity_err_q <= parity_err_d;
            data_out_q   <= data_out_d;
        end
    end

    assign z          = z_q;
    assign frame_done = frame_done_q;
    assign parity_err = parity_err_q;
    assign data_out   = data_out_q;

`ifdef PARITY_ERRCNT_EN
    // Bump the counter on the same edge that raises frame_done with an error,
    // so err_count and parity_err change together.
    logic err_hit;
    assign err_hit = x_valid && (state_q == S_PAR) && (x != (z_q ^ mode_q));

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_hit),
        .count (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_frame_parity_checker.sv
// Directed scoreboard bench for frame_parity_checker (DATA_BITS=8, CNT_W=2).
module tb_frame_parity_checker;

    localparam int DB  = 8;
    localparam int CW  = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          x;
    logic          x_valid;
    logic          odd_mode;
    logic          z;
    logic          frame_done;
    logic          parity_err;
    logic [DB-1:0] data_out;
    logic [CW-1:0] err_count;

    frame_parity_checker #(
        .DATA_BITS (DB),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .x_valid    (x_valid),
        .odd_mode   (odd_mode),
        .z          (z),
        .frame_done (frame_done),
        .parity_err (parity_err),
        .data_out   (data_out),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            pass_cnt = 0;
    int            total    = 0;
    logic [DB-1:0] last_data = '0;
    logic          last_err  = 1'b0;
    int            exp_cnt   = 0;
    logic          exp_z     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Drive one cycle, then sample just after the rising edge
    task automatic step(input logic xv, input logic xb, input logic r);
        rst     = r;
        x_valid = xv;
        x       = xb;
        @(posedge clk);
        #1;
    endtask

    // Checks for any cycle that does not complete a frame
    task automatic chk_quiet(input string tag);
        chk({tag, ".z"}, 32'(z), 32'(exp_z));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, ".data_out"}, 32'(data_out), 32'(last_data));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(last_err));
        chk({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
    endtask

    task automatic gap(input int max_gap, input string tag);
        int n;
        n = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (n) begin
            step(1'b0, 1'b0, 1'b0);
            chk_quiet({tag, ".gap"});
        end
    endtask

    // Send one frame; expected result is pushed on issue and popped when
    // frame_done is observed. flip toggles odd_mode after the first bit.
    task automatic send_frame(input string tag, input logic [DB-1:0] d, input logic p,
                              input int max_gap, input logic flip);
        exp_t e;
        e.data = d;
        e.err  = p ^ (^d) ^ odd_mode;
        sb.push_back(e);
        for (int i = 0; i < DB; i++) begin
            gap(max_gap, tag);
            step(1'b1, d[i], 1'b0);
            exp_z = exp_z ^ d[i];
            chk_quiet({tag, ".bit"});
            if (flip && i == 0) odd_mode = ~odd_mode;
        end
        gap(max_gap, tag);
        step(1'b1, p, 1'b0);
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s.scoreboard got=empty exp=entry", tag);
        end else begin
            e = sb.pop_front();
            last_data = e.data;
            last_err  = e.err;
`ifdef PARITY_ERRCNT_EN
            if (e.err && exp_cnt < CNT_MAX) exp_cnt++;
`endif
            exp_z = 1'b0;
            chk({tag, ".frame_done"}, 32'(frame_done), 32'd1);
            chk({tag, ".data_out"}, 32'(data_out), 32'(e.data));
            chk({tag, ".parity_err"}, 32'(parity_err), 32'(e.err));
            chk({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
            chk({tag, ".z_clr"}, 32'(z), 32'd0);
        end
    endtask

    initial begin
        logic [DB-1:0] part;
        rst      = 1'b1;
        x        = 1'b0;
        x_valid  = 1'b0;
        odd_mode = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk_quiet("reset");

        // Even mode, good and bad parity
        send_frame("a5_good", 8'hA5, 1'b0, 0, 1'b0);
        send_frame("a5_bad",  8'hA5, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_quiet("hold1");

        // Odd mode
        odd_mode = 1'b1;
        send_frame("odd_01", 8'h01, 1'b0, 0, 1'b0);

        // Random gaps between bits
        odd_mode = 1'b0;
        send_frame("gaps_3c", 8'h3C, 1'b0, 5, 1'b0);
        send_frame("gaps_3c_bad", 8'h3C, 1'b1, 5, 1'b0);

        // Mode change mid-frame must not affect the frame in flight
        odd_mode = 1'b0;
        send_frame("flip_03", 8'h03, 1'b0, 2, 1'b1);
        odd_mode = 1'b1;
        send_frame("flip_odd", 8'h07, 1'b0, 0, 1'b1);

        // Back-to-back frames, no idle cycle
        odd_mode = 1'b0;
        send_frame("b2b_ff", 8'hFF, 1'b0, 0, 1'b0);
        send_frame("b2b_80", 8'h80, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_quiet("hold2");

        // Reset in the middle of a frame discards it and clears outputs
        part = 8'h1B;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, part[i], 1'b0);
            exp_z = exp_z ^ part[i];
        end
        chk("pre_rst.z", 32'(z), 32'(exp_z));
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        last_data = '0;
        last_err  = 1'b0;
        exp_cnt   = 0;
        exp_z     = 1'b0;
        chk_quiet("mid_rst");
        rst = 1'b0;
        send_frame("post_rst_0f", 8'h0F, 1'b0, 0, 1'b0);

        // Error counter saturation
        for (int k = 0; k < 5; k++) begin
            send_frame($sformatf("sat%0d", k), 8'h00, 1'b1, 1, 1'b0);
        end
        send_frame("sat_good", 8'h00, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_quiet("final");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
